as_core: RTL and testbench

AS_CORE -- requirements
Module: as_core

---
 rtl/as_core_if.sv | 9 +
 rtl/as_core.sv | 179 +++++++++++++++++
 tb/tb_as_core.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/as_core_if.sv
// Program-load / debug bus of as_core: load strobe, instruction word, debug output.
interface as_core_if;
  logic        we;
  logic [31:0] din;
  logic [14:0] dout;

  modport master (output we, output din, input dout);
  modport slave  (input we, input din, output dout);
endinterface

// File: rtl/as_core.sv
// as_core: single-cycle RV32I integer subset with a 64-word program memory
// loaded through the bus while we=1. Define AS_CORE_BRANCH_EN to add
// BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR; otherwise those opcodes are NOPs.
module as_core (
  input  logic        clk,
  input  logic        rst_n,
  as_core_if.slave    bus
);

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`ifdef AS_CORE_BRANCH_EN
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
`endif

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] regs [NUM_REGS];
  logic [31:0] pc;
  logic [5:0]  load_ptr;
  logic [14:0] dout_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
`ifdef AS_CORE_BRANCH_EN
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic        taken;
`endif

  logic        wb_en;
  logic [31:0] wb_val;
  logic [31:0] pc_next;

  // Field extraction and operand fetch for the instruction at PC.
  always_comb begin
    instr   = imem[pc[7:2]];
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    funct7  = instr[31:25];
    rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    imm_i   = {{20{instr[31]}}, instr[31:20]};
    imm_u   = {instr[31:12], 12'd0};
`ifdef AS_CORE_BRANCH_EN
    imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`endif
  end

  // Decode/ALU: write-back value, write enable and next PC.
  always_comb begin
    wb_en   = 1'b0;
    wb_val  = 32'd0;
    pc_next = pc + 32'd4;
`ifdef AS_CORE_BRANCH_EN
    taken   = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        wb_en = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: wb_val = rs1_val + rs2_val;
          {7'h20, 3'd0}: wb_val = rs1_val - rs2_val;
          {7'h00, 3'd1}: wb_val = rs1_val << rs2_val[4:0];
          {7'h00, 3'd2}: wb_val = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          {7'h00, 3'd3}: wb_val = {31'd0, rs1_val < rs2_val};
          {7'h00, 3'd4}: wb_val = rs1_val ^ rs2_val;
          {7'h00, 3'd5}: wb_val = rs1_val >> rs2_val[4:0];
          {7'h20, 3'd5}: wb_val = 32'($signed(rs1_val) >>> rs2_val[4:0]);
          {7'h00, 3'd6}: wb_val = rs1_val | rs2_val;
          {7'h00, 3'd7}: wb_val = rs1_val & rs2_val;
          default:       wb_en  = 1'b0;
        endcase
      end
      OP_I: begin
        wb_en = 1'b1;
        case (funct3)
          3'd0: wb_val = rs1_val + imm_i;
          3'd2: wb_val = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          3'd3: wb_val = {31'd0, rs1_val < imm_i};
          3'd4: wb_val = rs1_val ^ imm_i;
          3'd6: wb_val = rs1_val | imm_i;
          3'd7: wb_val = rs1_val & imm_i;
          3'd1: begin
            if (funct7 == 7'h00) wb_val = rs1_val << rs2;
            else                 wb_en  = 1'b0;
          end
          default: begin
            if (funct7 == 7'h00)      wb_val = rs1_val >> rs2;
            else if (funct7 == 7'h20) wb_val = 32'($signed(rs1_val) >>> rs2);
            else                      wb_en  = 1'b0;
          end
        endcase
      end
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OP_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
`ifdef AS_CORE_BRANCH_EN
      OP_BR: begin
        case (funct3)
          3'd0:    taken = (rs1_val == rs2_val);
          3'd1:    taken = (rs1_val != rs2_val);
          3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'd6:    taken = (rs1_val <  rs2_val);
          3'd7:    taken = (rs1_val >= rs2_val);
          default: taken = 1'b0;
        endcase
        if (taken) pc_next = pc + imm_b;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) begin
          wb_en   = 1'b1;
          wb_val  = pc + 32'd4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.we) imem[load_ptr] <= bus.din;
  end

  // Architectural state: PC, load pointer, register file, debug output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 32'd0;
      load_ptr <= 6'd0;
      dout_q   <= 15'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (bus.we) begin
      pc       <= 32'd0;
      load_ptr <= load_ptr + 6'd1;
    end else begin
      pc       <= pc_next;
      load_ptr <= 6'd0;
      if (wb_en && (rd != 5'd0)) begin
        regs[rd] <= wb_val;
        dout_q   <= wb_val[14:0];
      end
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_as_core.sv
// Randomized bench for as_core: an instruction-level interpreter tracks the
// expected debug output; a single compare process checks it after every edge.
module tb_as_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  as_core_if bus ();
  as_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          check_en    = 1'b0;
  bit          lit_en      = 1'b0;
  logic [14:0] lit_val     = 15'd0;
  string       lit_name    = "";

  // Reference machine state
  logic [31:0] m_imem [64];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc;
  int unsigned m_lp;
  logic [14:0] m_dout;

  task automatic model_reset();
    m_pc   = 32'd0;
    m_lp   = 0;
    m_dout = 15'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  // Interpret one clock edge with the given bus inputs.
  task automatic model_step(input logic w, input logic [31:0] d);
    logic [31:0] ins, a, b, ii, val, npc, ib, ij;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, sh;
    logic        wr, t;
    if (w) begin
      m_imem[m_lp] = d;
      m_lp = (m_lp + 1) % 64;
      m_pc = 32'd0;
      return;
    end
    m_lp = 0;
    ins = m_imem[m_pc[7:2]];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sh  = ins[24:20];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    wr  = 1'b0;
    val = 32'd0;
    t   = 1'b0;
    npc = m_pc + 32'd4;
    case (ins[6:0])
      7'h33: begin
        wr = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0: val = (f7 == 7'h20) ? a - b : a + b;
          3'd1: val = a << b[4:0];
          3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: val = (a < b) ? 32'd1 : 32'd0;
          3'd4: val = a ^ b;
          3'd5: val = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: val = a | b;
          default: val = a & b;
        endcase
      end
      7'h13: begin
        wr = (f3 == 3'd1) ? (f7 == 7'h00) :
             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        case (f3)
          3'd0: val = a + ii;
          3'd1: val = a << sh;
          3'd2: val = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: val = (a < ii) ? 32'd1 : 32'd0;
          3'd4: val = a ^ ii;
          3'd5: val = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: val = a | ii;
          default: val = a & ii;
        endcase
      end
      7'h37: begin wr = 1'b1; val = {ins[31:12], 12'd0}; end
      7'h17: begin wr = 1'b1; val = m_pc + {ins[31:12], 12'd0}; end
`ifdef AS_CORE_BRANCH_EN
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) <  $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a <  b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) npc = m_pc + ib;
      end
      7'h6f: begin wr = 1'b1; val = m_pc + 32'd4; npc = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin
        wr = 1'b1; val = m_pc + 32'd4; npc = (a + ii) & ~32'd1;
      end
`endif
      default: ;
    endcase
    if (wr && rd != 5'd0) begin
      m_x[rd] = val;
      m_dout  = val[14:0];
    end
    m_pc = npc;
  endtask

  // Random instruction from the supported set plus NOP-class opcodes.
  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [12:0] ob;
    logic [20:0] oj;
    logic [6:0]  opc;
    int k, s;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    k   = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        s = $urandom_range(0, 9);
        case (s)
          0: return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
          1: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
          7: return {7'h20, rs2, rs1, 3'd5, rd, 7'h33};
          8: return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
          9: return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
          default: return {7'h00, rs2, rs1, 3'(s - 1), rd, 7'h33};
        endcase
      end
      2, 3, 9: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
        if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
        return {imm, rs1, f3, rd, 7'h13};
      end
      4: return {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      5: begin
        s = $urandom_range(0, 3);
        opc = (s == 0) ? 7'h03 : (s == 1) ? 7'h23 : (s == 2) ? 7'h0f : 7'h73;
        return {25'($urandom), opc};
      end
      6: begin
        s = $urandom_range(0, 5);
        f3 = (s < 2) ? 3'(s) : 3'(s + 2);
        ob = 13'($urandom_range(0, 32) * 2 - 32);
        return {ob[12], ob[10:5], rs2, rs1, f3, ob[4:1], ob[11], 7'h63};
      end
      7: begin
        oj = 21'($urandom_range(0, 32) * 2 - 32);
        return {oj[20], oj[10:1], oj[11], oj[19:12], rd, 7'h6f};
      end
      default: return {imm, rs1, 3'd0, rd, 7'h67};
    endcase
  endfunction

  // Compare DUT against the model (and any literal) after every edge and reset.
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    if (check_en) begin
      vectors++;
      if (bus.dout !== m_dout) begin
        miscompares++;
        $display("FAIL model_dout t=%0t got=%h exp=%h", $time, bus.dout, m_dout);
      end
      if (lit_en) begin
        vectors++;
        if (bus.dout !== lit_val) begin
          miscompares++;
          $display("FAIL %s t=%0t got=%h exp=%h", lit_name, $time, bus.dout, lit_val);
        end
      end
    end
  end

  task automatic cycle(input logic w, input logic [31:0] d);
    @(negedge clk);
    lit_en  = 1'b0;
    bus.we  = w;
    bus.din = d;
    model_step(w, d);
  endtask

  task automatic cycle_lit(input logic w, input logic [31:0] d,
                           input logic [14:0] e, input string n);
    cycle(w, d);
    lit_val  = e;
    lit_name = n;
    lit_en   = 1'b1;
  endtask

  // Short reset pulse between edges, then inputs for the following edge.
  task automatic reset_pulse(input logic w, input logic [31:0] d,
                             input bit chk, input logic [14:0] e, input string n);
    @(negedge clk);
    lit_val  = 15'd0;
    lit_name = "async_reset";
    lit_en   = 1'b1;
    model_reset();
    rst_n = 1'b0;
    #3;
    rst_n   = 1'b1;
    lit_en  = 1'b0;
    bus.we  = w;
    bus.din = d;
    model_step(w, d);
    if (chk) begin
      lit_val  = e;
      lit_name = n;
      lit_en   = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_imem[i] = 32'd0;
    model_reset();
    rst_n   = 1'b0;
    bus.we  = 1'b1;
    bus.din = 32'd0;
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;
    bus.din  = 32'h00500093;
    model_step(1'b1, 32'h00500093);
    lit_val = 15'd0; lit_name = "reset_dout"; lit_en = 1'b1;

    // ADDI x1,x0,5
    cycle_lit(1'b0, 32'h0, 15'h0005, "addi");

    // ADDI/ADDI/ADD
    cycle(1'b1, 32'h00500093);
    cycle(1'b1, 32'h00700113);
    cycle(1'b1, 32'h002081B3);
    cycle_lit(1'b0, 32'h0, 15'h0005, "add_seq0");
    cycle_lit(1'b0, 32'h0, 15'h0007, "add_seq1");
    cycle_lit(1'b0, 32'h0, 15'h000C, "add_seq2");

    // Reset mid-run restarts at imem[0] with cleared registers
    cycle(1'b1, 32'h00500093);
    cycle(1'b1, 32'h00700113);
    cycle(1'b1, 32'h002081B3);
    cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    reset_pulse(1'b0, 32'h0, 1'b1, 15'h0005, "restart_pc0");
    cycle_lit(1'b0, 32'h0, 15'h0007, "restart_seq1");
    cycle_lit(1'b0, 32'h0, 15'h000C, "restart_seq2");

    // LUI then write to x0
    cycle(1'b1, 32'h123452B7);
    cycle(1'b1, 32'h00900013);
    cycle_lit(1'b0, 32'h0, 15'h5000, "lui");
    cycle_lit(1'b0, 32'h0, 15'h5000, "x0_write");

    // SUB to zero, negative immediate
    cycle(1'b1, 32'h00500093);
    cycle(1'b1, 32'h40108133);
    cycle(1'b1, 32'hFFF00193);
    cycle_lit(1'b0, 32'h0, 15'h0005, "sub_seq0");
    cycle_lit(1'b0, 32'h0, 15'h0000, "sub_zero");
    cycle_lit(1'b0, 32'h0, 15'h7FFF, "addi_neg");

    // BEQ x0,x0,0 followed by ADDI x1,x0,9
    cycle(1'b1, 32'h00500093);
    cycle(1'b1, 32'h00000063);
    cycle(1'b1, 32'h00900093);
    cycle_lit(1'b0, 32'h0, 15'h0005, "br_seq0");
    cycle_lit(1'b0, 32'h0, 15'h0005, "br_self");
`ifdef AS_CORE_BRANCH_EN
    cycle_lit(1'b0, 32'h0, 15'h0005, "br_hold");
`else
    cycle_lit(1'b0, 32'h0, 15'h0009, "br_nop");
`endif

    // Reset mid-load: loading restarts at index 0
    cycle(1'b1, 32'h00700113);
    cycle(1'b1, 32'h00700113);
    reset_pulse(1'b1, 32'h00300093, 1'b0, 15'h0, "");
    cycle_lit(1'b0, 32'h0, 15'h0003, "load_restart");

    // Random programs
    for (int r = 0; r < 10; r++) begin
      if (r % 3 == 1) begin
        for (int i = 0; i < int'($urandom_range(1, 40)); i++) cycle(1'b1, gen_instr());
        reset_pulse(1'b1, gen_instr(), 1'b0, 15'h0, "");
        for (int i = 1; i < 64; i++) cycle(1'b1, gen_instr());
      end else begin
        if (r % 3 == 2) reset_pulse(1'b0, $urandom, 1'b0, 15'h0, "");
        for (int i = 0; i < 64; i++) cycle(1'b1, gen_instr());
      end
      for (int i = 0; i < 150; i++) cycle(1'b0, $urandom);
    end

    @(negedge clk);
    lit_en   = 1'b0;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
